ctrl_fsm: RTL

- Multi-cycle control sequencer for the unpipelined WiscSP13 core.
- Fetches an instruction, decodes opcode/funct, and produces the 5-bit ALU_fn consumed by the EX-stage ALU controller.
- Drives register-file, memory and PC-update strobes per phase.
- Owns all instruction sequencing, memory stalls and halt.

---
 rtl/ctrl_fsm.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ctrl_fsm : multi-cycle control sequencer for the unpipelined WiscSP13 core.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// decodes opcode/funct into the 5-bit ALU function code and drives the
// register-file, data-memory and PC-update strobes for each phase. A HALT
// opcode parks the sequencer in HALT until reset.
//
// Ports
//   clk          core clock
//   rst_n        synchronous active-low reset
//   instr_in     instruction word from imem, valid when imem_rdy=1
//   imem_rdy     imem has data this cycle
//   dmem_done    data-memory access complete
//   br_taken     branch condition from EX, sampled in WB
//   imem_req     instruction fetch request
//   ALU_fn       ALU function code for EX, held from DECODE through WB
//   reg_wr_en    register-file write strobe (WB only)
//   reg_dst_sel  00 instr[4:2], 01 instr[7:5], 10 instr[10:8], 11 R7
//   mem_rd       data read request
//   mem_wr       data write request
//   mem_to_reg   WB source is memory data
//   pc_wr        PC update strobe (WB only)
//   pc_src       00 PC+2, 01 branch target, 10 jump disp, 11 register+imm
//   link         WB data is PC+2 (JAL/JALR)
//   halt         sticky halted flag
//   err          one-cycle pulse on siic/RTI decode
//   state_dbg    current state encoding
//   retired_cnt  retired-instruction counter (only with CTRL_PERF_CNT_EN)
//
// Build option
//   CTRL_PERF_CNT_EN : adds retired_cnt, counting WB cycles (wraps at 16 bits).
// ---------------------------------------------------------------------------
module ctrl_fsm #(
   parameter int unsigned INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               imem_rdy,
   input  logic               dmem_done,
   input  logic               br_taken,
   output logic               imem_req,
   output logic [4:0]         ALU_fn,
   output logic               reg_wr_en,
   output logic [1:0]         reg_dst_sel,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic               mem_to_reg,
   output logic               pc_wr,
   output logic [1:0]         pc_src,
   output logic               link,
   output logic               halt,
   output logic               err,
   output logic [2:0]         state_dbg
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [15:0]        retired_cnt
`endif
);

   localparam int unsigned OP_W  = 5;
   localparam int unsigned FN_W  = 2;
   localparam int unsigned ALU_W = 5;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   // Per-instruction control word captured when the fetch is accepted
   typedef struct packed {
      logic [ALU_W-1:0] alu_fn;
      logic [1:0]       dst;
      logic             reg_wr;
      logic [1:0]       pc_src;
      logic             link;
      logic             mem_to_reg;
      logic             mem_rd;
      logic             mem_wr;
      logic             branch;
      logic             halt;
   } ctl_t;

   localparam ctl_t CTL_RST = '{alu_fn: 5'b11111, default: '0};

   // Opcode/funct to control word
   function automatic ctl_t decode(input logic [OP_W-1:0] op, input logic [FN_W-1:0] fn);
      ctl_t c;
      c        = '0;
      c.alu_fn = 5'b11111;
      case (op)
         5'b00000: c.halt = 1'b1;
         5'b00001, 5'b00010, 5'b00011: ;   // NOP, siic, RTI: PC+2 only
         5'b00100: begin                    // J
            c.alu_fn = 5'b11100;
            c.pc_src = 2'b10;
         end
         5'b00101: begin                    // JR
            c.alu_fn = 5'b11101;
            c.pc_src = 2'b11;
         end
         5'b00110: begin                    // JAL
            c.alu_fn = 5'b11100;
            c.pc_src = 2'b10;
            c.link   = 1'b1;
            c.reg_wr = 1'b1;
            c.dst    = 2'b11;
         end
         5'b00111: begin                    // JALR
            c.alu_fn = 5'b11101;
            c.pc_src = 2'b11;
            c.link   = 1'b1;
            c.reg_wr = 1'b1;
            c.dst    = 2'b11;
         end
         5'b01000, 5'b01001, 5'b01010, 5'b01011: begin   // ADDI..ANDNI
            c.alu_fn = {3'b000, op[1:0]};
            c.reg_wr = 1'b1;
            c.dst    = 2'b01;
         end
         5'b01100, 5'b01101, 5'b01110, 5'b01111: begin   // BEQZ..BGEZ
            c.alu_fn = 5'b10110 + {3'b000, op[1:0]};
            c.branch = 1'b1;
         end
         5'b10000: begin                    // ST
            c.alu_fn = 5'b01000;
            c.mem_wr = 1'b1;
         end
         5'b10001: begin                    // LD
            c.alu_fn     = 5'b01000;
            c.mem_rd     = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_wr     = 1'b1;
            c.dst        = 2'b01;
         end
         5'b10010: begin                    // SLBI
            c.alu_fn = 5'b11011;
            c.reg_wr = 1'b1;
            c.dst    = 2'b10;
         end
         5'b10011: begin                    // STU writes back the updated base
            c.alu_fn = 5'b01000;
            c.mem_wr = 1'b1;
            c.reg_wr = 1'b1;
            c.dst    = 2'b10;
         end
         5'b10100, 5'b10101, 5'b10110, 5'b10111: begin   // ROLI..SRLI
            c.alu_fn = {3'b001, op[1:0]};
            c.reg_wr = 1'b1;
            c.dst    = 2'b01;
         end
         5'b11000: begin                    // LBI
            c.alu_fn = 5'b11010;
            c.reg_wr = 1'b1;
            c.dst    = 2'b10;
         end
         5'b11001: begin                    // BTR
            c.alu_fn = 5'b01001;
            c.reg_wr = 1'b1;
            c.dst    = 2'b10;
         end
         5'b11010: begin                    // ROL/SLL/ROR/SRL
            c.alu_fn = 5'b01110 + {3'b000, fn};
            c.reg_wr = 1'b1;
         end
         5'b11011: begin                    // ADD/SUB/XOR/ANDN
            c.alu_fn = 5'b01010 + {3'b000, fn};
            c.reg_wr = 1'b1;
         end
         5'b11100, 5'b11101, 5'b11110, 5'b11111: begin   // SEQ/SLT/SLE/SCO
            c.alu_fn = 5'b10010 + {3'b000, op[1:0]};
            c.reg_wr = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   logic [OP_W-1:0] opcode;
   logic [FN_W-1:0] funct;
   logic            unused_instr_bits;

   assign opcode            = instr_in[INSTR_W-1 -: OP_W];
   assign funct             = instr_in[FN_W-1:0];
   assign unused_instr_bits = ^instr_in[INSTR_W-OP_W-1:FN_W];

   state_t     state, state_d;
   ctl_t       ctl_q, ctl_d;
   logic       err_d, imem_req_d, reg_wr_d, pc_wr_d, link_d, m2r_d;
   logic       mem_rd_d, mem_wr_d, halt_d;
   logic [1:0] pc_src_q, pc_src_d;

   // Next-state and next-output logic
   always_comb begin
      state_d    = state;
      ctl_d      = ctl_q;
      err_d      = 1'b0;
      imem_req_d = 1'b0;
      reg_wr_d   = 1'b0;
      pc_wr_d    = 1'b0;
      pc_src_d   = 2'b00;
      link_d     = 1'b0;
      m2r_d      = 1'b0;
      mem_rd_d   = 1'b0;
      mem_wr_d   = 1'b0;
      halt_d     = 1'b0;

      unique case (state)
         FETCH: begin
            // Accept only once the registered request is visible to imem
            if (imem_req && imem_rdy) begin
               state_d = DECODE;
               ctl_d   = decode(opcode, funct);
               err_d   = (opcode == 5'b00010) || (opcode == 5'b00011);
            end
         end
         DECODE:  state_d = ctl_q.halt ? HALT : EXEC;
         EXEC:    state_d = (ctl_q.mem_rd || ctl_q.mem_wr) ? MEM : WB;
         MEM:     if (dmem_done) state_d = WB;
         WB:      state_d = FETCH;
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase

      // Strobes are registered, so they follow the state being entered
      imem_req_d = (state_d == FETCH);
      halt_d     = (state_d == HALT);
      if (state_d == MEM) begin
         mem_rd_d = ctl_q.mem_rd;
         mem_wr_d = ctl_q.mem_wr;
      end
      if (state_d == WB) begin
         pc_wr_d  = 1'b1;
         reg_wr_d = ctl_q.reg_wr;
         pc_src_d = ctl_q.pc_src;
         link_d   = ctl_q.link;
         m2r_d    = ctl_q.mem_to_reg;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= FETCH;
         ctl_q      <= CTL_RST;
         err        <= 1'b0;
         imem_req   <= 1'b0;
         reg_wr_en  <= 1'b0;
         pc_wr      <= 1'b0;
         pc_src_q   <= 2'b00;
         link       <= 1'b0;
         mem_to_reg <= 1'b0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         halt       <= 1'b0;
      end else begin
         state      <= state_d;
         ctl_q      <= ctl_d;
         err        <= err_d;
         imem_req   <= imem_req_d;
         reg_wr_en  <= reg_wr_d;
         pc_wr      <= pc_wr_d;
         pc_src_q   <= pc_src_d;
         link       <= link_d;
         mem_to_reg <= m2r_d;
         mem_rd     <= mem_rd_d;
         mem_wr     <= mem_wr_d;
         halt       <= halt_d;
      end
   end

   assign ALU_fn      = ctl_q.alu_fn;
   assign reg_dst_sel = ctl_q.dst;
   assign state_dbg   = state;

   // br_taken is only resolved by EX during WB, so the taken bit is merged here
   assign pc_src = pc_src_q | {1'b0, (state == WB) && ctl_q.branch && br_taken};

`ifdef CTRL_PERF_CNT_EN
   // Retired-instruction counter; no WB cycles occur in HALT, so it freezes there
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retired_cnt <= '0;
      end else if (state == WB) begin
         retired_cnt <= retired_cnt + 16'd1;
      end
   end
`endif

endmodule
